mc_maindec: RTL and testbench

- Multicycle main control unit for the MIPS datapath; the parametrised sequential successor of the single-cycle main decoder.
- Decodes the same opcode set (R-type, ADDI, BEQ, J, JAL, SW, LW) into per-state control strokes.
- Talks to a shared instruction/data memory through a req/rdy handshake, with an optional wait timeout.
- Sits between the instruction register's opcode field and the multicycle datapath's muxes and write enables.

---
 rtl/mc_maindec.sv | 207 ++++++++++++++++++++
 tb/tb_mc_maindec.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM with req/rdy memory handshake and optional wait timeout.
// Define MC_MAINDEC_INSTR_CNT_EN to add the retired-instruction counter output instr_cnt.
module mc_maindec #(
    parameter int OPCODE_W = 6,
    parameter int TIMEOUT  = 0,
    parameter int TO_W     = 8,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_rdy,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          reg_dst,
    output logic                we_reg,
    output logic                dm2reg,
    output logic                pc2reg,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_to,
    output logic [3:0]          state
`ifdef MC_MAINDEC_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_JAL     = 4'd12, S_ILLEGAL = 4'd13
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic       we_reg;
        logic       dm2reg;
        logic       pc2reg;
        logic       instr_done;
        logic       illegal;
        logic       mem_to;
    } ctl_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'h03);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2b);

    if (TIMEOUT < 0 || (TO_W < 31 && TIMEOUT >= (1 << TO_W)) || CNT_W < 1) begin : g_bad_cfg
        $error("mc_maindec: TIMEOUT must be in [0, 2**TO_W) and CNT_W >= 1");
    end

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            in_mem, timeout;
    ctl_t            ctl;

    always_comb begin
        in_mem  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout = (TIMEOUT > 0) && in_mem && !mem_rdy && (wait_q == TO_W'(TIMEOUT - 1));
        // Any exit from a memory state (or non-memory state) leaves the counter at 0.
        wait_d  = '0;
        if (in_mem && !mem_rdy && !timeout)
            wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;

        state_d = S_FETCH;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_we     = mem_rdy;
                ctl.pc_we     = mem_rdy;
                state_d       = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD: begin
                ctl.mem_req = 1'b1;
                ctl.iord    = 1'b1;
                state_d     = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctl.dm2reg     = 1'b1;
                ctl.we_reg     = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_req    = 1'b1;
                ctl.mem_we     = 1'b1;
                ctl.iord       = 1'b1;
                ctl.instr_done = mem_rdy;
                state_d        = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_dst    = 2'b01;
                ctl.we_reg     = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_op     = 2'b01;
                ctl.pc_src     = 2'b01;
                ctl.pc_we      = zero;
                ctl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.we_reg     = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_src     = 2'b10;
                ctl.pc_we      = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctl.pc_src     = 2'b10;
                ctl.pc_we      = 1'b1;
                ctl.reg_dst    = 2'b10;
                ctl.pc2reg     = 1'b1;
                ctl.we_reg     = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_ILLEGAL: ctl.illegal = 1'b1;
            default: ;
        endcase
        // mem_rdy already excluded from timeout, so a same-cycle completion wins.
        if (timeout) state_d = S_FETCH;
        ctl.mem_to = timeout;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
            reg_dst, we_reg, dm2reg, pc2reg, instr_done, illegal, mem_to} = rst ? ctl : '0;
    assign state = rst ? state_q : 4'd0;

`ifdef MC_MAINDEC_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = cnt_q + CNT_W'(instr_done);

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: per-instruction expected traces built from the state/strobe table,
// checked every cycle on an unbounded-wait instance (A) and a TIMEOUT=4 instance (B).
module tb_mc_maindec;

    localparam int TO_B = 4;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op, reg_dst;
        logic       we_reg, dm2reg, pc2reg, instr_done, illegal, mem_to;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic       z;
        logic       rdy;
        ctl_t       c;
    } rec_t;

    logic clk = 1'b0, rst = 1'b0, zero = 1'b0, mem_rdy = 1'b0;
    logic [5:0] opcode = '0;

    logic mem_req_a, mem_we_a, iord_a, ir_we_a, pc_we_a, alu_src_a_a, we_reg_a, dm2reg_a;
    logic pc2reg_a, instr_done_a, illegal_a, mem_to_a;
    logic [1:0] pc_src_a, alu_src_b_a, alu_op_a, reg_dst_a;
    logic [3:0] state_a;
    logic mem_req_b, mem_we_b, iord_b, ir_we_b, pc_we_b, alu_src_a_b, we_reg_b, dm2reg_b;
    logic pc2reg_b, instr_done_b, illegal_b, mem_to_b;
    logic [1:0] pc_src_b, alu_src_b_b, alu_op_b, reg_dst_b;
    logic [3:0] state_b;
`ifdef MC_MAINDEC_INSTR_CNT_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    ctl_t obs_a, obs_b;
    assign obs_a = {state_a, mem_req_a, mem_we_a, iord_a, ir_we_a, pc_we_a, pc_src_a, alu_src_a_a,
                    alu_src_b_a, alu_op_a, reg_dst_a, we_reg_a, dm2reg_a, pc2reg_a, instr_done_a,
                    illegal_a, mem_to_a};
    assign obs_b = {state_b, mem_req_b, mem_we_b, iord_b, ir_we_b, pc_we_b, pc_src_b, alu_src_a_b,
                    alu_src_b_b, alu_op_b, reg_dst_b, we_reg_b, dm2reg_b, pc2reg_b, instr_done_b,
                    illegal_b, mem_to_b};

    always #5 clk = ~clk;

    mc_maindec #(.OPCODE_W(6), .TIMEOUT(0), .TO_W(8), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .iord(iord_a), .ir_we(ir_we_a), .pc_we(pc_we_a),
        .pc_src(pc_src_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a),
        .reg_dst(reg_dst_a), .we_reg(we_reg_a), .dm2reg(dm2reg_a), .pc2reg(pc2reg_a),
        .instr_done(instr_done_a), .illegal(illegal_a), .mem_to(mem_to_a), .state(state_a)
`ifdef MC_MAINDEC_INSTR_CNT_EN
        , .instr_cnt(cnt_a)
`endif
    );

    mc_maindec #(.OPCODE_W(6), .TIMEOUT(TO_B), .TO_W(8), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .ir_we(ir_we_b), .pc_we(pc_we_b),
        .pc_src(pc_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
        .reg_dst(reg_dst_b), .we_reg(we_reg_b), .dm2reg(dm2reg_b), .pc2reg(pc2reg_b),
        .instr_done(instr_done_b), .illegal(illegal_b), .mem_to(mem_to_b), .state(state_b)
`ifdef MC_MAINDEC_INSTR_CNT_EN
        , .instr_cnt(cnt_b)
`endif
    );

    ctl_t base[16];
    rec_t exp_q[$];
    int   n_run = 0, n_fail = 0;
    int   cnt_m = 0;

    task automatic init_base();
        for (int s = 0; s < 16; s++) begin
            base[s] = '0;
            base[s].st = 4'(s);
        end
        base[0].mem_req = 1; base[0].alu_src_b = 2'b01;
        base[1].alu_src_b = 2'b11;
        base[2].alu_src_a = 1; base[2].alu_src_b = 2'b10;
        base[3].mem_req = 1; base[3].iord = 1;
        base[4].dm2reg = 1; base[4].we_reg = 1; base[4].instr_done = 1;
        base[5].mem_req = 1; base[5].mem_we = 1; base[5].iord = 1;
        base[6].alu_src_a = 1; base[6].alu_op = 2'b10;
        base[7].reg_dst = 2'b01; base[7].we_reg = 1; base[7].instr_done = 1;
        base[8].alu_src_a = 1; base[8].alu_op = 2'b01; base[8].pc_src = 2'b01; base[8].instr_done = 1;
        base[9].alu_src_a = 1; base[9].alu_src_b = 2'b10;
        base[10].we_reg = 1; base[10].instr_done = 1;
        base[11].pc_src = 2'b10; base[11].pc_we = 1; base[11].instr_done = 1;
        base[12].pc_src = 2'b10; base[12].pc_we = 1; base[12].reg_dst = 2'b10;
        base[12].pc2reg = 1; base[12].we_reg = 1; base[12].instr_done = 1;
        base[13].illegal = 1;
    endtask

    function automatic ctl_t exp_vec(int s, logic rdy, logic z, logic mto);
        ctl_t c = base[s];
        if (s == 0) begin c.ir_we = rdy; c.pc_we = rdy; end
        if (s == 8) c.pc_we = z;
        if (s == 5) c.instr_done = rdy;
        c.mem_to = mto;
        return c;
    endfunction

    task automatic push(logic [5:0] op, logic z, int s, logic rdy, logic mto);
        rec_t r;
        r.op = op; r.z = z; r.rdy = rdy; r.c = exp_vec(s, rdy, z, mto);
        exp_q.push_back(r);
    endtask

    // w cycles of no-ready then a ready cycle; a timeout abandons the instruction.
    task automatic mem_phase(logic [5:0] op, logic z, int s, int w, int to, output bit ab);
        ab = 0;
        for (int i = 0; i < w; i++) begin
            if (to > 0 && i == to - 1) begin
                push(op, z, s, 1'b0, 1'b1);
                ab = 1;
                return;
            end
            push(op, z, s, 1'b0, 1'b0);
        end
        push(op, z, s, 1'b1, 1'b0);
    endtask

    task automatic build(logic [5:0] op, logic z, int wf, int wm, int to);
        bit ab;
        mem_phase(op, z, 0, wf, to, ab);
        if (ab) return;
        push(op, z, 1, 1'($urandom), 1'b0);
        case (op)
            OP_LW: begin
                push(op, z, 2, 1'($urandom), 1'b0);
                mem_phase(op, z, 3, wm, to, ab);
                if (!ab) push(op, z, 4, 1'($urandom), 1'b0);
            end
            OP_SW: begin
                push(op, z, 2, 1'($urandom), 1'b0);
                mem_phase(op, z, 5, wm, to, ab);
            end
            OP_R:    begin push(op, z, 6, 1'($urandom), 1'b0); push(op, z, 7, 1'($urandom), 1'b0); end
            OP_ADDI: begin push(op, z, 9, 1'($urandom), 1'b0); push(op, z, 10, 1'($urandom), 1'b0); end
            OP_BEQ:  push(op, z, 8, 1'($urandom), 1'b0);
            OP_J:    push(op, z, 11, 1'($urandom), 1'b0);
            OP_JAL:  push(op, z, 12, 1'($urandom), 1'b0);
            default: push(op, z, 13, 1'($urandom), 1'b0);
        endcase
    endtask

    // Entered and left at a falling edge; each record is one clock cycle.
    task automatic run_trace(string name, bit use_b, int limit);
        rec_t r;
        ctl_t obs;
        int k = 0;
        while (exp_q.size() > 0 && (limit < 0 || k < limit)) begin
            r = exp_q.pop_front();
            opcode = r.op; zero = r.z; mem_rdy = r.rdy;
            #1;
            obs = use_b ? obs_b : obs_a;
            n_run++;
            if (obs !== r.c) begin
                n_fail++;
                $display("FAIL %s step %0d: got %h (state %0d) expected %h (state %0d)",
                         name, k, obs, obs.st, r.c, r.c.st);
            end
            if (r.c.instr_done) cnt_m++;
            @(negedge clk);
            k++;
        end
        exp_q.delete();
`ifdef MC_MAINDEC_INSTR_CNT_EN
        n_run++;
        if ((use_b ? cnt_b : cnt_a) !== 32'(cnt_m)) begin
            n_fail++;
            $display("FAIL %s instr_cnt: got %0d expected %0d", name, use_b ? cnt_b : cnt_a, cnt_m);
        end
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0; mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt_m = 0;
    endtask

    function automatic bit legal(logic [5:0] op);
        return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

    task automatic test_reset();
        rst = 1'b0; mem_rdy = 1'b1; opcode = OP_LW;
        repeat (3) begin
            #1;
            n_run++;
            if (obs_a !== '0 || obs_b !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got a=%h b=%h expected 0", obs_a, obs_b);
            end
`ifdef MC_MAINDEC_INSTR_CNT_EN
            n_run++;
            if (cnt_a !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_cnt: got %0d expected 0", cnt_a);
            end
`endif
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_run++;
        if (obs_a !== exp_vec(0, 1'b1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs_a, exp_vec(0, 1'b1, 1'b0, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_addi_rtype();
        do_reset();
        build(OP_ADDI, 1'b0, 0, 0, 0);
        build(OP_R, 1'b1, 0, 0, 0);
        run_trace("addi_rtype", 0, -1);
    endtask

    task automatic test_lw_wait();
        do_reset();
        build(OP_LW, 1'b0, 0, 2, 0);
        build(OP_SW, 1'b0, 1, 3, 0);
        run_trace("lw_wait", 0, -1);
    endtask

    task automatic test_beq();
        do_reset();
        build(OP_BEQ, 1'b1, 0, 0, 0);
        build(OP_BEQ, 1'b0, 0, 0, 0);
        run_trace("beq", 0, -1);
    endtask

    task automatic test_jal_illegal();
        do_reset();
        build(OP_JAL, 1'b0, 0, 0, 0);
        build(6'h3f, 1'b0, 0, 0, 0);
        build(OP_J, 1'b1, 0, 0, 0);
        run_trace("jal_illegal", 0, -1);
    endtask

    task automatic test_mid_reset();
        do_reset();
        build(OP_LW, 1'b0, 0, 2, 0);
        run_trace("mid_reset_pre", 0, 4);
        rst = 1'b0; mem_rdy = 1'b1;
        #1;
        n_run++;
        if (obs_a !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got %h expected 0", obs_a);
        end
        @(negedge clk);
        rst = 1'b1; mem_rdy = 1'b0;
        #1;
        n_run++;
        if (obs_a !== exp_vec(0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL mid_reset_fetch: got %h expected %h", obs_a, exp_vec(0, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        build(OP_SW, 1'b0, 0, 6, TO_B);
        build(OP_J, 1'b0, 0, 0, TO_B);
        run_trace("timeout_sw", 1, -1);
        build(OP_ADDI, 1'b0, 5, 0, TO_B);
        build(OP_LW, 1'b0, 3, 3, TO_B);
        build(OP_LW, 1'b0, 0, 4, TO_B);
        build(OP_ADDI, 1'b0, 0, 0, TO_B);
        run_trace("timeout_fetch", 1, -1);
    endtask

    task automatic test_random(bit use_b);
        logic [5:0] ops[7] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
        logic [5:0] op;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 6)];
            end
            build(op, 1'($urandom), $urandom_range(0, use_b ? 5 : 3), $urandom_range(0, use_b ? 6 : 4),
                  use_b ? TO_B : 0);
            run_trace(use_b ? "random_b" : "random_a", use_b, -1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_base();
        @(negedge clk);
        test_reset();
        test_addi_rtype();
        test_lw_wait();
        test_beq();
        test_jal_illegal();
        test_mid_reset();
        test_timeout();
        test_random(1'b0);
        test_random(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
